// File: rtl/pipe_stage_latch.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_latch
// Description : Parametrised inter-stage pipeline register. Carries an
//               instruction word plus NUM_CH data channels, a valid bit,
//               a bubble marker and a saturating stall-age counter.
//               Per-edge priority: reset > flush > enable > hold.
//               Optional statistics counters are compiled in when the
//               macro PIPE_STAGE_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_latch #(
    parameter int          DATA_W = 32,
    parameter int          NUM_CH = 2,
    parameter logic [31:0] NOP_IR = 32'h00000000,
    parameter int          AGE_W  = 4
) (
    input  wire logic                     clock,
    input  wire logic                     reset,
    input  wire logic                     in_enable,
    input  wire logic                     in_flush,
    input  wire logic                     in_valid,
    input  wire logic [31:0]              in_ir,
    input  wire logic [NUM_CH*DATA_W-1:0] in_data,
    output logic      [31:0]              out_ir,
    output logic      [NUM_CH*DATA_W-1:0] out_data,
    output logic                          out_valid,
    output logic      [AGE_W-1:0]         out_age,
    output logic                          out_bubble
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic      [31:0]              out_stall_cnt,
    output logic      [31:0]              out_flush_cnt,
    output logic      [31:0]              out_squash_cnt
`endif
);

    localparam logic [AGE_W-1:0] c_AGE_MAX = {AGE_W{1'b1}};
    localparam logic [31:0]      c_CNT_MAX = 32'hFFFFFFFF;

    logic [31:0]              r_ir;
    logic [NUM_CH*DATA_W-1:0] r_data;
    logic                     r_valid;
    logic                     r_bubble;
    logic [AGE_W-1:0]         r_age;

    // A hold cycle is any non-reset, non-flush edge with enable low.
    logic w_hold;
    assign w_hold = ~in_flush & ~in_enable;

    // Entry register: reset and flush both load a NOP bubble, capture takes
    // the upstream entry, otherwise everything holds and only the age moves.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ir     <= NOP_IR;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_bubble <= 1'b1;
            r_age    <= '0;
        end else if (in_flush) begin
            r_ir     <= NOP_IR;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_bubble <= 1'b1;
            r_age    <= '0;
        end else if (in_enable) begin
            r_ir     <= in_ir;
            r_data   <= in_data;
            r_valid  <= in_valid;
            r_bubble <= 1'b0;
            r_age    <= '0;
        end else if (r_valid && (r_age != c_AGE_MAX)) begin
            // Only a real instruction ages; bubbles and invalid entries stay at 0.
            r_age    <= r_age + AGE_W'(1);
        end
    end

    assign out_ir     = r_ir;
    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign out_bubble = r_bubble;
    assign out_age    = r_age;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_squash_cnt;

    // Saturating event counters observed from this stage boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (w_hold && r_valid && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (in_flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            // A squash is a flush that throws away a real instruction.
            if (in_flush && r_valid && (r_squash_cnt != c_CNT_MAX)) begin
                r_squash_cnt <= r_squash_cnt + 32'd1;
            end
        end
    end

    assign out_stall_cnt  = r_stall_cnt;
    assign out_flush_cnt  = r_flush_cnt;
    assign out_squash_cnt = r_squash_cnt;
`else
    // Hold qualifier only feeds the statistics block.
    logic w_unused;
    assign w_unused = w_hold ^ c_CNT_MAX[0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_latch
// Description : Self-checking bench for pipe_stage_latch (NUM_CH=2,
//               DATA_W=32, AGE_W=4). Directed scenarios followed by random
//               traffic, all compared against a behavioural entry model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_latch;

    localparam int          DATA_W = 32;
    localparam int          NUM_CH = 2;
    localparam int          AGE_W  = 4;
    localparam logic [31:0] NOP_IR = 32'h00000000;

    logic                     clock;
    logic                     reset;
    logic                     in_enable;
    logic                     in_flush;
    logic                     in_valid;
    logic [31:0]              in_ir;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [31:0]              out_ir;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic                     out_valid;
    logic [AGE_W-1:0]         out_age;
    logic                     out_bubble;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]              out_stall_cnt;
    logic [31:0]              out_flush_cnt;
    logic [31:0]              out_squash_cnt;
`endif

    pipe_stage_latch #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .NOP_IR (NOP_IR),
        .AGE_W  (AGE_W)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .in_enable      (in_enable),
        .in_flush       (in_flush),
        .in_valid       (in_valid),
        .in_ir          (in_ir),
        .in_data        (in_data),
        .out_ir         (out_ir),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_age        (out_age),
        .out_bubble     (out_bubble)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .out_stall_cnt  (out_stall_cnt),
        .out_flush_cnt  (out_flush_cnt),
        .out_squash_cnt (out_squash_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: the entry as a set of plain values, with age kept as
    // an unbounded count of held cycles and clamped only when compared.
    logic [31:0]              m_ir;
    logic [NUM_CH*DATA_W-1:0] m_data;
    logic                     m_valid;
    logic                     m_bubble;
    int                       m_held;
    longint                   m_stall;
    longint                   m_flush;
    longint                   m_squash;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'sh00000000FFFFFFFF) ? 32'hFFFFFFFF : v[31:0];
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_ir = NOP_IR; m_data = '0; m_valid = 1'b0; m_bubble = 1'b1; m_held = 0;
            m_stall = 0; m_flush = 0; m_squash = 0;
        end else if (in_flush) begin
            m_flush++;
            if (m_valid) m_squash++;
            m_ir = NOP_IR; m_data = '0; m_valid = 1'b0; m_bubble = 1'b1; m_held = 0;
        end else if (in_enable) begin
            m_ir = in_ir; m_data = in_data; m_valid = in_valid; m_bubble = 1'b0; m_held = 0;
        end else if (m_valid) begin
            m_held++;
            m_stall++;
        end
    endtask

    // One clock: the model follows the inputs present at the edge, then the
    // outputs are compared shortly after it.
    task automatic tick();
        int exp_age;
        @(posedge clock);
        model_edge();
        #1;
        exp_age = (m_held > (2**AGE_W - 1)) ? (2**AGE_W - 1) : m_held;
        check_val("ir",     {32'd0, out_ir},   {32'd0, m_ir});
        check_val("data",   out_data,          m_data);
        check_val("valid",  {63'd0, out_valid},  {63'd0, m_valid});
        check_val("bubble", {63'd0, out_bubble}, {63'd0, m_bubble});
        check_val("age",    {60'd0, out_age},    64'(exp_age));
`ifdef PIPE_STAGE_STATS_EN
        check_val("stall_cnt",  {32'd0, out_stall_cnt},  {32'd0, sat32(m_stall)});
        check_val("flush_cnt",  {32'd0, out_flush_cnt},  {32'd0, sat32(m_flush)});
        check_val("squash_cnt", {32'd0, out_squash_cnt}, {32'd0, sat32(m_squash)});
`endif
    endtask

    task automatic drive(input logic rst, input logic fl, input logic en, input logic v,
                         input logic [31:0] ir, input logic [63:0] d);
        reset = rst; in_flush = fl; in_enable = en; in_valid = v; in_ir = ir; in_data = d;
    endtask

    initial begin
        m_ir = '0; m_data = '0; m_valid = 1'b0; m_bubble = 1'b0; m_held = 0;
        m_stall = 0; m_flush = 0; m_squash = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0);

        // Reset for one cycle.
        tick();
        check_val("reset_ir_const", {32'd0, out_ir}, {32'd0, NOP_IR});
        check_val("reset_bubble_const", {63'd0, out_bubble}, 64'd1);

        // Capture a real instruction.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0A2B0005, {32'hDEADBEEF, 32'h00000010});
        tick();
        check_val("cap_data_const", out_data, {32'hDEADBEEF, 32'h00000010});

        // Stall 20 cycles with changing inputs; age saturates at 15.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b0, i[0], $urandom, {$urandom, $urandom});
            tick();
        end
        check_val("age_sat_const", {60'd0, out_age}, 64'd15);

        // Flush during stall squashes the valid entry.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF0000, 64'h1234);
        tick();

        // Priority: reset over flush and enable, then flush over enable.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h11111111, 64'h22);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 64'h5555);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 64'h5555);
        tick();
        check_val("flush_beats_enable", {63'd0, out_valid}, 64'd0);

        // Invalid passthrough then three stalls with age held at 0.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 64'hABCD);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, $urandom, {$urandom, $urandom});
            tick();
        end
        check_val("invalid_ir_const", {32'd0, out_ir}, 64'h12345678);

        // Random traffic, biased toward stalls so the age counter saturates.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(99) < 2), ($urandom_range(99) < 8),
                  ($urandom_range(99) < 35), $urandom_range(1) == 1,
                  $urandom, {$urandom, $urandom});
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
